// File: rtl/qkd_pkg.sv
// Shared BB84 definitions: qubit/basis encodings, sifting FSM states and
// the measurement and LFSR step helpers used by both link ends.
package qkd_pkg;

    localparam logic [1:0]  QB_ZERO           = 2'b00;
    localparam logic [1:0]  QB_PLUS           = 2'b01;
    localparam logic [1:0]  QB_ONE            = 2'b10;
    localparam logic [1:0]  QB_MINUS          = 2'b11;
    localparam logic        BASIS_RECT        = 1'b0;
    localparam logic        BASIS_DIAG        = 1'b1;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RECV       = 3'd1,
        ANNOUNCE   = 3'd2,
        WAIT_ALICE = 3'd3,
        DONE       = 3'd4
    } sift_state_e;

    // qubit[0] is the encoding basis and qubit[1] the bit; a wrong basis yields the fill bit
    function automatic logic meas_bit(input logic [1:0] qb, input logic basis, input logic fill);
        logic m;
        if (qb[0] == basis) begin
            m = qb[1];
        end else begin
            m = fill;
        end
        return m;
    endfunction

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/qkd_lfsr16.sv
// 16-bit Fibonacci LFSR with enable; shared by the Alice and Bob sequencers.
import qkd_pkg::*;

module qkd_lfsr16 #(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [15:0] state
);

    // An all-zero seed would lock the register up, so it falls back to the default
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    logic [15:0] lfsr_r;

    // Shift register: advances only when enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_r <= SEED_EFF;
        end else if (adv) begin
            lfsr_r <= lfsr16_next(lfsr_r);
        end
    end

    assign state = lfsr_r;

endmodule

// File: rtl/bob_sift_ctrl.sv
// Receiver-side BB84 sequencer: random-basis measurement, basis announce,
// sifting against Alice's basis and key accumulation.
import qkd_pkg::*;

module bob_sift_ctrl #(
    parameter int          KEY_LEN   = 16,
    parameter int          TIMEOUT   = 255,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               qubit_valid,
    output logic               qubit_ready,
    input  logic [1:0]         qubit,
    output logic               bob_basis,
    output logic               bob_basis_valid,
    input  logic               alice_basis,
    input  logic               alice_basis_valid,
    output logic [KEY_LEN-1:0] key,
    output logic [6:0]         key_count,
    output logic [15:0]        discard_count,
    output logic               done
);

    localparam logic [6:0]  KEY_LEN_C  = 7'(KEY_LEN);
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    sift_state_e        state_r, state_s;
    logic [15:0]        lfsr_s;
    logic               lfsr_unused_s;
    logic               accept_s, match_s, expire_s, key_full_s;
    logic               clear_s, keep_s, drop_s;
    logic               ready_s, strobe_s, done_s;
    logic               qubit_ready_r, bob_basis_r, bob_basis_valid_r, done_r;
    logic               meas_r;
    logic [15:0]        timer_r;
    logic [KEY_LEN-1:0] key_r;
    logic [6:0]         key_count_r;
    logic [15:0]        discard_count_r;

    qkd_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (accept_s),
        .state (lfsr_s)
    );

    // Only the two low LFSR bits feed the measurement
    assign lfsr_unused_s = ^lfsr_s[15:2];

    assign accept_s   = (state_r == RECV) && qubit_valid;
    assign match_s    = alice_basis_valid && (alice_basis == bob_basis_r);
    assign expire_s   = (timer_r == TIMEOUT_M1);
    assign key_full_s = ((key_count_r + 7'd1) == KEY_LEN_C);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a valid answer on the expiry cycle wins over the timeout
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:       state_s = start ? RECV : IDLE;
            RECV:       state_s = qubit_valid ? ANNOUNCE : RECV;
            ANNOUNCE:   state_s = WAIT_ALICE;
            WAIT_ALICE: begin
                if (alice_basis_valid) begin
                    state_s = (match_s && key_full_s) ? DONE : RECV;
                end else if (expire_s) begin
                    state_s = RECV;
                end else begin
                    state_s = WAIT_ALICE;
                end
            end
            DONE:       state_s = start ? RECV : DONE;
            default:    state_s = IDLE;
        endcase
    end

    // Output/control decode; status flags are computed for the next state so they register cleanly
    always_comb begin
        ready_s  = (state_s == RECV);
        strobe_s = (state_s == ANNOUNCE);
        done_s   = (state_s == DONE);
        clear_s  = 1'b0;
        keep_s   = 1'b0;
        drop_s   = 1'b0;
        if (state_r == WAIT_ALICE) begin
            keep_s = match_s;
            drop_s = alice_basis_valid ? !match_s : expire_s;
        end else if ((state_r == IDLE) || (state_r == DONE)) begin
            clear_s = start;
        end else begin
            clear_s = 1'b0;
        end
    end

    // Registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qubit_ready_r     <= 1'b0;
            bob_basis_valid_r <= 1'b0;
            done_r            <= 1'b0;
        end else begin
            qubit_ready_r     <= ready_s;
            bob_basis_valid_r <= strobe_s;
            done_r            <= done_s;
        end
    end

    // Measurement latch, reply timer and key/discard accounting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bob_basis_r     <= 1'b0;
            meas_r          <= 1'b0;
            timer_r         <= 16'd0;
            key_r           <= '0;
            key_count_r     <= 7'd0;
            discard_count_r <= 16'd0;
        end else begin
            if (accept_s) begin
                bob_basis_r <= lfsr_s[0];
                meas_r      <= meas_bit(qubit, lfsr_s[0], lfsr_s[1]);
            end
            if (state_r == ANNOUNCE) begin
                timer_r <= 16'd0;
            end else if (state_r == WAIT_ALICE) begin
                timer_r <= timer_r + 16'd1;
            end
            if (clear_s) begin
                key_r           <= '0;
                key_count_r     <= 7'd0;
                discard_count_r <= 16'd0;
            end else begin
                if (keep_s) begin
                    for (int i = 0; i < KEY_LEN; i++) begin
                        if (key_count_r == 7'(i)) begin
                            key_r[i] <= meas_r;
                        end
                    end
                    key_count_r <= key_count_r + 7'd1;
                end
                if (drop_s && (discard_count_r != 16'hFFFF)) begin
                    discard_count_r <= discard_count_r + 16'd1;
                end
            end
        end
    end

    assign qubit_ready     = qubit_ready_r;
    assign bob_basis       = bob_basis_r;
    assign bob_basis_valid = bob_basis_valid_r;
    assign key             = key_r;
    assign key_count       = key_count_r;
    assign discard_count   = discard_count_r;
    assign done            = done_r;

endmodule

// File: tb/tb_bob_sift_ctrl.sv
// Scoreboard bench for bob_sift_ctrl: a driver feeds qubits and Alice replies
// while a monitor checks announces and key/count updates against a reference model.
module tb_bob_sift_ctrl;

    localparam int KL = 4;
    localparam int TO = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          qubit_valid = 1'b0;
    logic [1:0]    qubit = 2'b00;
    logic          alice_basis = 1'b0;
    logic          alice_basis_valid = 1'b0;
    logic          qubit_ready, bob_basis, bob_basis_valid, done;
    logic [KL-1:0] key;
    logic [6:0]    key_count;
    logic [15:0]   discard_count;

    bob_sift_ctrl #(.KEY_LEN(KL), .TIMEOUT(TO), .LFSR_SEED(16'hACE1)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .qubit_valid       (qubit_valid),
        .qubit_ready       (qubit_ready),
        .qubit             (qubit),
        .bob_basis         (bob_basis),
        .bob_basis_valid   (bob_basis_valid),
        .alice_basis       (alice_basis),
        .alice_basis_valid (alice_basis_valid),
        .key               (key),
        .key_count         (key_count),
        .discard_count     (discard_count),
        .done              (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [KL-1:0] key;
        logic [6:0]    cnt;
        logic [15:0]   disc;
        logic          dn;
    } res_t;

    int          n_chk = 0;
    int          n_pass = 0;
    logic        ann_q[$];
    res_t        res_q[$];
    logic [15:0] m_lfsr;
    logic        m_bits[$];
    int          m_disc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: taps 16,14,13,11 in right-shift form
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        int fb;
        fb = (s >> 0 ^ s >> 2 ^ s >> 3 ^ s >> 5) & 1;
        return 16'((int'(s) >> 1) | (fb << 15));
    endfunction

    function automatic res_t snap();
        res_t r;
        r.key = '0;
        foreach (m_bits[i]) r.key[i] = m_bits[i];
        r.cnt  = 7'(m_bits.size());
        r.disc = 16'(m_disc);
        r.dn   = (m_bits.size() == KL);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        m_bits.delete();
        m_disc = 0;
        res_q.push_back(snap());
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One qubit: in_basis forces qubit[0] to Bob's basis; d = reply delay in WAIT cycles (d>=TO: no reply)
    task automatic send_qubit(input bit in_basis, input logic bitv, input int d, input bit match);
        int n;
        logic b, fill, meas;
        logic [1:0] q;
        n = 0;
        while (!qubit_ready && n < 20) begin tick(); n++; end
        chk("ready_wait", qubit_ready, 1);
        b    = m_lfsr[0];
        fill = m_lfsr[1];
        q    = in_basis ? {bitv, b} : 2'($urandom_range(0, 3));
        meas = (q[0] == b) ? q[1] : fill;
        m_lfsr = lfsr_step(m_lfsr);
        ann_q.push_back(b);
        qubit = q;
        qubit_valid = 1'b1;
        tick();
        qubit_valid = 1'($urandom_range(0, 1));
        qubit = 2'($urandom_range(0, 3));
        chk("strobe_latency", bob_basis_valid, 1);
        tick();
        for (int k = 0; k < d && k < TO; k++) begin
            start = 1'($urandom_range(0, 1));
            qubit_valid = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        if (d < TO) begin
            alice_basis_valid = 1'b1;
            alice_basis = match ? b : ~b;
            if (match) m_bits.push_back(meas);
            else if (m_disc < 65535) m_disc++;
            res_q.push_back(snap());
            tick();
            alice_basis_valid = 1'b0;
        end else begin
            if (m_disc < 65535) m_disc++;
            res_q.push_back(snap());
        end
        qubit_valid = 1'b0;
    endtask

    task automatic finish_random();
        int n;
        n = 0;
        while (m_bits.size() < KL && n < 80) begin
            send_qubit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, TO), 1'($urandom_range(0, 1)));
            n++;
        end
        chk("session_done", done, 1);
    endtask

    // Monitor: announce strobes and key/count updates (ready or done rising)
    logic prev_rdy = 1'b0;
    logic prev_dn  = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rdy <= 1'b0;
            prev_dn  <= 1'b0;
        end else begin
            if (bob_basis_valid) begin
                chk("ann_pending", ann_q.size() != 0, 1);
                if (ann_q.size() != 0) chk("bob_basis", bob_basis, ann_q.pop_front());
            end
            if ((qubit_ready && !prev_rdy) || (done && !prev_dn)) begin
                chk("res_pending", res_q.size() != 0, 1);
                if (res_q.size() != 0) begin
                    res_t e;
                    e = res_q.pop_front();
                    chk("key", key, e.key);
                    chk("key_count", key_count, e.cnt);
                    chk("discard_count", discard_count, e.disc);
                    chk("done", done, e.dn);
                end
            end
            prev_rdy <= qubit_ready;
            prev_dn  <= done;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] bits;
        // Reset with noisy inputs
        m_lfsr = 16'hACE1;
        rst_n = 1'b0; start = 1'b1; qubit_valid = 1'b1;
        repeat (3) tick();
        chk("rst_ready", qubit_ready, 0);
        chk("rst_basis", bob_basis, 0);
        chk("rst_strobe", bob_basis_valid, 0);
        chk("rst_key", key, 0);
        chk("rst_count", key_count, 0);
        chk("rst_disc", discard_count, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1; start = 1'b0; qubit_valid = 1'b0;
        tick(); tick();
        chk("idle_ready", qubit_ready, 0);

        // Matching sift: key bits 1,0,1,1
        bits = 4'b1101;
        start_session();
        for (int i = 0; i < KL; i++) send_qubit(1'b1, bits[i], 2, 1'b1);
        chk("t2_key", key, bits);
        chk("t2_done", done, 1);
        chk("t2_disc", discard_count, 0);

        // Mismatches, then timeout and valid-on-expiry
        start_session();
        repeat (3) send_qubit(1'b1, 1'b1, 1, 1'b0);
        send_qubit(1'b1, 1'b1, 1, 1'b1);
        chk("t3_disc", discard_count, 3);
        chk("t3_count", key_count, 1);
        chk("t3_key0", key[0], 1);
        send_qubit(1'b1, 1'b0, TO, 1'b1);
        chk("t4_timeout_disc", discard_count, 4);
        chk("t4_timeout_ready", qubit_ready, 1);
        send_qubit(1'b1, 1'b1, TO - 1, 1'b1);
        chk("t4_expiry_count", key_count, 2);
        chk("t4_expiry_disc", discard_count, 4);
        finish_random();

        // Restarts with the LFSR carrying on
        repeat (3) begin
            start_session();
            finish_random();
        end

        // Mid-operation reset with two bits kept
        start_session();
        send_qubit(1'b1, 1'b1, 0, 1'b1);
        send_qubit(1'b1, 1'b0, 3, 1'b1);
        chk("t6_pre_count", key_count, 2);
        send_qubit(1'b1, 1'b1, TO, 1'b0);
        while (!qubit_ready) tick();
        qubit = 2'b00; qubit_valid = 1'b1;
        ann_q.push_back(m_lfsr[0]);
        tick();
        qubit_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        m_lfsr = 16'hACE1;
        chk("t6_count", key_count, 0);
        chk("t6_key", key, 0);
        chk("t6_disc", discard_count, 0);
        chk("t6_ready", qubit_ready, 0);
        rst_n = 1'b1;
        tick(); tick();
        chk("t6_idle", qubit_ready, 0);
        start_session();
        finish_random();

        tick(); tick();
        chk("ann_q_empty", ann_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
